parity_checker: RTL and testbench

//  Receive side of the 14-bit systematic parity code: accepts a codeword
//  {p[13:0], c[13:0]}, recomputes parity from c, forms syndrome s = p ^ P(c),
//  and classifies each word.
//  Two-stage elastic valid/ready pipeline between link deserialiser and consumer.

---
 rtl/parity_checker.sv | 120 ++++++++++++
 tb/tb_parity_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_checker.sv
// rtl/parity_checker.sv - 14-bit systematic parity receive checker on a two-stage elastic pipeline
// Optional build macro PARITY_CHECKER_STATS_EN adds saturating word/perr/derr counters.
module parity_checker #(
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [13:0] in_c,
   input  logic [13:0] in_p,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [13:0] out_c,
   output logic [13:0] out_syn,
   output logic        out_perr,
   output logic        out_derr,
   output logic        err_sticky,
   input  logic        clr
`ifdef PARITY_CHECKER_STATS_EN
   ,
   output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] perr_cnt,
   output logic [CNT_W-1:0] derr_cnt
`endif
);

   localparam logic [13:0] ROW [14] = '{
      14'h3652, 14'h2F93, 14'h07EE, 14'h3759, 14'h27EC, 14'h0646, 14'h3CC1,
      14'h2B5D, 14'h38CF, 14'h203F, 14'h06CE, 14'h0AA4, 14'h1399, 14'h27BC
   };

   function automatic logic [13:0] parity(input logic [13:0] c);
      logic [13:0] r;
      r = '0;
      for (int i = 0; i < 14; i++) r[i] = ^(c & ROW[i]);
      return r;
   endfunction

   logic        s1_valid;
   logic [13:0] s1_c;
   logic [13:0] s1_s;
   logic        s2_valid;
   logic [13:0] s2_c;
   logic [13:0] s2_s;
   logic        s2_perr;
   logic        s2_derr;
   logic        adv2;
   logic        consume;
   logic        s1_onehot;
   logic        s1_zero;

   // Ready depends only on stage occupancy and out_ready, never on in_valid.
   assign adv2     = ~s2_valid | out_ready;
   assign in_ready = ~s1_valid | adv2;
   assign consume  = s2_valid & out_ready;

   assign s1_zero   = (s1_s == 14'd0);
   assign s1_onehot = ~s1_zero && ((s1_s & (s1_s - 14'd1)) == 14'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_c     <= '0;
         s1_s     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_c <= in_c;
            s1_s <= in_p ^ parity(in_c);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_c     <= '0;
         s2_s     <= '0;
         s2_perr  <= 1'b0;
         s2_derr  <= 1'b0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_c    <= s1_c;
            s2_s    <= s1_s;
            s2_perr <= s1_onehot;
            s2_derr <= ~s1_zero & ~s1_onehot;
         end
      end
   end

   // A word reporting an error outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst)                              err_sticky <= 1'b0;
      else if (consume & (s2_perr | s2_derr)) err_sticky <= 1'b1;
      else if (clr)                         err_sticky <= 1'b0;
   end

   assign out_valid = s2_valid;
   assign out_c     = s2_c;
   assign out_syn   = s2_s;
   assign out_perr  = s2_perr;
   assign out_derr  = s2_derr;

`ifdef PARITY_CHECKER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         word_cnt <= '0;
         perr_cnt <= '0;
         derr_cnt <= '0;
      end else if (consume) begin
         if (word_cnt != '1)             word_cnt <= word_cnt + 1'b1;
         if (s2_perr && perr_cnt != '1)  perr_cnt <= perr_cnt + 1'b1;
         if (s2_derr && derr_cnt != '1)  derr_cnt <= derr_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_parity_checker.sv
// tb/tb_parity_checker.sv - scoreboard bench for parity_checker
// Counter checks are built when PARITY_CHECKER_STATS_EN is defined.
module tb_parity_checker;

   typedef struct packed {
      logic [13:0] c;
      logic [13:0] syn;
      logic        perr;
      logic        derr;
   } word_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [13:0] in_c = '0;
   logic [13:0] in_p = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [13:0] out_c;
   logic [13:0] out_syn;
   logic        out_perr;
   logic        out_derr;
   logic        err_sticky;
   logic        clr = 1'b0;
`ifdef PARITY_CHECKER_STATS_EN
   logic [3:0]  word_cnt;
   logic [3:0]  perr_cnt;
   logic [3:0]  derr_cnt;
`endif

   int total = 0;
   int bad   = 0;
   word_t q[$];

   always #5 clk = ~clk;

`ifdef PARITY_CHECKER_STATS_EN
   parity_checker #(.CNT_W(4)) dut (
`else
   parity_checker dut (
`endif
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_c(in_c), .in_p(in_p), .out_valid(out_valid), .out_ready(out_ready),
      .out_c(out_c), .out_syn(out_syn), .out_perr(out_perr), .out_derr(out_derr),
      .err_sticky(err_sticky), .clr(clr)
`ifdef PARITY_CHECKER_STATS_EN
      , .word_cnt(word_cnt), .perr_cnt(perr_cnt), .derr_cnt(derr_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every presented word against the queue head; pops on consumption.
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word actual=%h required=none at %0t", out_c, $time);
         end else begin
            chk("out_c", 32'(out_c), 32'(q[0].c));
            chk("out_syn", 32'(out_syn), 32'(q[0].syn));
            chk("out_perr", 32'(out_perr), 32'(q[0].perr));
            chk("out_derr", 32'(out_derr), 32'(q[0].derr));
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   task automatic send(input logic [13:0] c, input logic [13:0] p, input logic [13:0] syn,
                       input logic perr, input logic derr, input bit keep);
      bit acc;
      word_t w;
      acc = 0;
      w = '{c: c, syn: syn, perr: perr, derr: derr};
      in_c = c;
      in_p = p;
      in_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(w);
            acc = 1;
         end
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 60; t++) begin
         if (q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // c, p, syndrome, perr, derr; syndromes worked by hand from P(0001)=13CA, P(0002)=0727.
   logic [13:0] v_c   [8] = '{14'h0001, 14'h0002, 14'h0003, 14'h0001, 14'h0002, 14'h0003, 14'h0000, 14'h0000};
   logic [13:0] v_p   [8] = '{14'h13CA, 14'h0727, 14'h14ED, 14'h13CB, 14'h0000, 14'h34ED, 14'h0000, 14'h0003};
   logic [13:0] v_s   [8] = '{14'h0000, 14'h0000, 14'h0000, 14'h0001, 14'h0727, 14'h2000, 14'h0000, 14'h0003};
   logic        v_pe  [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
   logic        v_de  [8] = '{0, 0, 0, 0, 1, 0, 0, 1};

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_c", 32'(out_c), 32'd0);
      chk("rst_out_syn", 32'(out_syn), 32'd0);
      chk("rst_flags", 32'({out_perr, out_derr}), 32'd0);
      chk("rst_sticky", 32'(err_sticky), 32'd0);
      @(posedge clk);
      #1;

      // Clean word, two-cycle latency
      in_c = 14'h0001;
      in_p = 14'h13CA;
      in_valid = 1'b1;
      q.push_back('{c: 14'h0001, syn: 14'h0000, perr: 1'b0, derr: 1'b0});
      @(negedge clk);
      chk("lat_c0", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_c1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_c2", 32'(out_valid), 32'd1);
      drain();
      chk("t1_sticky", 32'(err_sticky), 32'd0);

      send(14'h0001, 14'h13EA, 14'h0020, 1'b1, 1'b0, 0);
      drain();
      chk("t2_sticky", 32'(err_sticky), 32'd1);

      send(14'h0001, 14'h0000, 14'h13CA, 1'b0, 1'b1, 0);
      drain();
      chk("t3_sticky", 32'(err_sticky), 32'd1);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chk("t3_clr", 32'(err_sticky), 32'd0);

      // Back-to-back stream with a four-cycle consumer stall
      fork
         begin
            for (int i = 0; i < 8; i++) send(v_c[i], v_p[i], v_s[i], v_pe[i], v_de[i], 1);
            in_valid = 1'b0;
         end
         begin
            for (int cyc = 0; cyc < 8; cyc++) begin
               out_ready = (cyc < 3 || cyc > 6);
               @(negedge clk);
               if (cyc == 4 || cyc == 6) chk("stall_in_ready", 32'(in_ready), 32'd0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      chk("t4_sticky", 32'(err_sticky), 32'd1);

      // Reset with both stages full
      out_ready = 1'b0;
      send(14'h0001, 14'h0000, 14'h13CA, 1'b0, 1'b1, 0);
      send(14'h0002, 14'h0000, 14'h0727, 1'b0, 1'b1, 0);
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_out_valid", 32'(out_valid), 32'd0);
      chk("t5_sticky", 32'(err_sticky), 32'd0);
      chk("t5_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      send(14'h0002, 14'h0727, 14'h0000, 1'b0, 1'b0, 0);
      drain();

`ifdef PARITY_CHECKER_STATS_EN
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      for (int i = 0; i < 20; i++) send(14'h0001, 14'h0000, 14'h13CA, 1'b0, 1'b1, 1);
      in_valid = 1'b0;
      drain();
      chk("derr_cnt_sat", 32'(derr_cnt), 32'hF);
      chk("word_cnt_sat", 32'(word_cnt), 32'hF);
      chk("perr_cnt", 32'(perr_cnt), 32'h0);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chk("cnt_clr", 32'({word_cnt, perr_cnt, derr_cnt}), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
